pll_lock_rst_gen: RTL and testbench

- Consumes the PLL `locked` indication in the 80 MHz baseband clock domain (PLL outclk 1).
- Generates the synchronous active-low reset for all downstream OFDM baseband logic, released only after lock has been stable and a hold-off period has elapsed.
- Once running, produces a 1-in-CE_DIV clock-enable strobe and phase count, so 20 MHz sample-rate logic runs on the 80 MHz clock.
- Tracks and flags PLL lock losses for status registers.

---
 rtl/pll_rst_pkg.sv | 18 +
 rtl/sync_bit.sv | 23 ++
 rtl/pll_lock_rst_gen.sv | 166 ++++++++++++++++
 tb/tb_pll_lock_rst_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock / baseband reset generator.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_HOLDOFF   = 2'd1,
        S_RUN       = 2'd2
    } pll_state_e;

    localparam int unsigned             DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0]   DROP_CNT_MAX = 8'hFF;

    // Saturating increment for the lock-drop counter.
    function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer with synchronous active-low clear.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic i_clr_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_rst_gen.sv
// PLL lock qualifier, baseband reset release and 1-in-CE_DIV sample enable.
// Optional drop counter enabled by defining PLL_LOCK_DROP_CNT_EN.
module pll_lock_rst_gen
    import pll_rst_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned GLITCH_CYCLES  = 8,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned CE_DIV         = 4,
    parameter int unsigned CE_W           = $clog2(CE_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  clr_flags,
    output logic                  sys_rst_n,
    output logic                  sym_ce,
    output logic [CE_W-1:0]       ce_phase,
    output logic                  lock_lost,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned GLT_W = $clog2(GLITCH_CYCLES + 1);
    localparam int unsigned HLD_W = $clog2(HOLDOFF_CYCLES + 1);

    localparam logic [GLT_W-1:0] GLT_LAST = GLT_W'(GLITCH_CYCLES);
    localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF_CYCLES);
    localparam logic [CE_W-1:0]  CE_LAST  = CE_W'(CE_DIV - 1);

    logic              w_lock_s;

    pll_state_e        r_state;
    pll_state_e        w_state_nxt;
    logic [GLT_W-1:0]  r_glitch_cnt;
    logic [GLT_W-1:0]  w_glitch_nxt;
    logic [GLT_W-1:0]  w_glitch_inc;
    logic [HLD_W-1:0]  r_hold_cnt;
    logic [HLD_W-1:0]  w_hold_nxt;
    logic              r_ce_en;
    logic              w_ce_en_nxt;
    logic [CE_W-1:0]   r_ce_phase;
    logic [CE_W-1:0]   w_ce_phase_nxt;
    logic              r_sys_rst_n;
    logic              w_sys_rst_n_nxt;
    logic              r_sym_ce;
    logic              w_sym_ce_nxt;
    logic              r_lock_lost;
    logic              w_lock_lost_nxt;
    logic              w_drop_evt;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk     (clk),
        .i_clr_n (rst_n),
        .i_d     (locked),
        .o_q     (w_lock_s)
    );

    assign w_glitch_inc = r_glitch_cnt + GLT_W'(1);

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_WAIT_LOCK;
            r_glitch_cnt <= '0;
            r_hold_cnt   <= '0;
            r_ce_en      <= 1'b0;
            r_ce_phase   <= '0;
            r_sys_rst_n  <= 1'b0;
            r_sym_ce     <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_glitch_cnt <= w_glitch_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_ce_en      <= w_ce_en_nxt;
            r_ce_phase   <= w_ce_phase_nxt;
            r_sys_rst_n  <= w_sys_rst_n_nxt;
            r_sym_ce     <= w_sym_ce_nxt;
            r_lock_lost  <= w_lock_lost_nxt;
        end
    end

    // Next-state and next-output logic; any exit to S_WAIT_LOCK clears everything.
    always_comb begin
        w_state_nxt     = r_state;
        w_glitch_nxt    = '0;
        w_hold_nxt      = '0;
        w_ce_en_nxt     = 1'b0;
        w_ce_phase_nxt  = '0;
        w_sys_rst_n_nxt = 1'b0;
        w_sym_ce_nxt    = 1'b0;
        w_drop_evt      = 1'b0;

        case (r_state)
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    if (w_glitch_inc == GLT_LAST) begin
                        w_state_nxt = S_HOLDOFF;
                    end else begin
                        w_glitch_nxt = w_glitch_inc;
                    end
                end
            end
            S_HOLDOFF: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (r_hold_cnt == HLD_LAST) begin
                    w_state_nxt     = S_RUN;
                    w_sys_rst_n_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HLD_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_drop_evt  = 1'b1;
                end else begin
                    w_sys_rst_n_nxt = 1'b1;
                    w_ce_en_nxt     = 1'b1;
                    // Baseband gets one settled cycle out of reset before the divider advances.
                    if (r_ce_en) begin
                        w_ce_phase_nxt = (r_ce_phase == CE_LAST) ? '0 : r_ce_phase + CE_W'(1);
                    end
                    w_sym_ce_nxt = (w_ce_phase_nxt == CE_LAST);
                end
            end
            default: begin
                w_state_nxt = S_WAIT_LOCK;
            end
        endcase

        // A new drop takes priority over a clear on the same edge.
        if (w_drop_evt) begin
            w_lock_lost_nxt = 1'b1;
        end else if (clr_flags) begin
            w_lock_lost_nxt = 1'b0;
        end else begin
            w_lock_lost_nxt = r_lock_lost;
        end
    end

`ifdef PLL_LOCK_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt) begin
            r_drop_cnt <= drop_sat_inc(r_drop_cnt);
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign sys_rst_n = r_sys_rst_n;
    assign sym_ce    = r_sym_ce;
    assign ce_phase  = r_ce_phase;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_pll_lock_rst_gen.sv
// Bench for pll_lock_rst_gen: vector table, corner sequences and a run-length reference model.
module tb_pll_lock_rst_gen;
    import pll_rst_pkg::*;

    localparam int SYNC = 2;
    localparam int GLT  = 4;
    localparam int HLD  = 16;
    localparam int CED  = 4;
    localparam int CEW  = 2;
    localparam int REL  = GLT + HLD + 1;
    localparam int LAT  = SYNC + GLT + HLD + 1;
`ifdef PLL_LOCK_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  locked;
    logic                  clr_flags;
    logic                  sys_rst_n;
    logic                  sym_ce;
    logic [CEW-1:0]        ce_phase;
    logic                  lock_lost;
    logic [DROP_CNT_W-1:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    pll_lock_rst_gen #(
        .SYNC_STAGES    (SYNC),
        .GLITCH_CYCLES  (GLT),
        .HOLDOFF_CYCLES (HLD),
        .CE_DIV         (CED)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .locked    (locked),
        .clr_flags (clr_flags),
        .sys_rst_n (sys_rst_n),
        .sym_ce    (sym_ce),
        .ce_phase  (ce_phase),
        .lock_lost (lock_lost),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_drop(input int n);
        if (!DROP_EN) return 0;
        return (n > 255) ? 255 : n;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_sys(input logic val, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (sys_rst_n === val) begin
                n = i;
                break;
            end
        end
    endtask

    // Reference: outputs follow from how long the synchronized lock has been continuously high.
    int hist[$];
    int m_run  = 0;
    bit m_lost = 1'b0;
    int m_drop = 0;

    always @(posedge clk) begin : mdl
        int ls;
        bit was_rel;
        if (!rst_n) begin
            hist.delete();
            m_run  = 0;
            m_lost = 1'b0;
            m_drop = 0;
        end else begin
            ls = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 0;
            hist.push_back(int'(locked));
            if (hist.size() > 8) void'(hist.pop_front());
            was_rel = (m_run >= REL);
            m_run   = (ls != 0) ? m_run + 1 : 0;
            if (was_rel && ls == 0) begin
                m_lost = 1'b1;
                if (DROP_EN && m_drop < 255) m_drop++;
            end else if (clr_flags) begin
                m_lost = 1'b0;
            end
        end
    end

    always @(negedge clk) begin : mchk
        int  r;
        int  ep;
        logic es;
        logic ec;
        if (chk_en) begin
            es = (m_run >= REL);
            r  = m_run - REL;
            ep = (!es || r == 0) ? 0 : (r - 1) % CED;
            ec = es && (ep == CED - 1);
            chk("model_sys_rst_n", 32'(sys_rst_n), 32'(es));
            chk("model_sym_ce",    32'(sym_ce),    32'(ec));
            chk("model_ce_phase",  32'(ce_phase),  32'(ep));
            chk("model_lock_lost", 32'(lock_lost), 32'(m_lost));
            chk("model_drop_cnt",  32'(drop_cnt),  32'(m_drop));
        end
    end

    typedef struct {
        int   e;
        logic s;
        logic c;
        int   p;
    } vec_t;

    initial begin : wdog
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t vecs[12];
        int   cur;
        int   n;
        int   len;

        vecs = '{'{1, 1'b0, 1'b0, 0}, '{22, 1'b0, 1'b0, 0}, '{23, 1'b1, 1'b0, 0},
                 '{24, 1'b1, 1'b0, 0}, '{25, 1'b1, 1'b0, 1}, '{26, 1'b1, 1'b0, 2},
                 '{27, 1'b1, 1'b1, 3}, '{28, 1'b1, 1'b0, 0}, '{30, 1'b1, 1'b0, 2},
                 '{31, 1'b1, 1'b1, 3}, '{34, 1'b1, 1'b0, 2}, '{35, 1'b1, 1'b1, 3}};

        rst_n     = 1'b0;
        locked    = 1'b0;
        clr_flags = 1'b0;
        @(negedge clk);
        step();
        step();
        chk("rst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("rst_sym_ce",    32'(sym_ce),    0);
        chk("rst_ce_phase",  32'(ce_phase),  0);
        chk("rst_lock_lost", 32'(lock_lost), 0);
        chk("rst_drop_cnt",  32'(drop_cnt),  0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        step();

        // Steady lock: edge 1 is the first edge sampling locked=1.
        locked = 1'b1;
        cur    = 0;
        for (int i = 0; i < 12; i++) begin
            while (cur < vecs[i].e) begin
                step();
                cur++;
            end
            chk($sformatf("steady_sys_e%0d", vecs[i].e),   32'(sys_rst_n), 32'(vecs[i].s));
            chk($sformatf("steady_ce_e%0d", vecs[i].e),    32'(sym_ce),    32'(vecs[i].c));
            chk($sformatf("steady_phase_e%0d", vecs[i].e), 32'(ce_phase),  32'(vecs[i].p));
        end

        // Drop from RUN, then relock.
        locked = 1'b0;
        wait_sys(1'b0, 10, n);
        chk("drop_lat_within_3", 32'(n >= 1 && n <= SYNC + 1), 1);
        chk("drop_lock_lost", 32'(lock_lost), 1);
        chk("drop_drop_cnt",  32'(drop_cnt),  32'(exp_drop(1)));
        chk("drop_sym_ce",    32'(sym_ce),    0);
        chk("drop_ce_phase",  32'(ce_phase),  0);
        locked = 1'b1;
        wait_sys(1'b1, 40, n);
        chk("relock_lat", 32'(n), 32'(LAT));

        // rst_n pulse mid-RUN with lock held.
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_sys_rst_n", 32'(sys_rst_n), 0);
        chk("midrst_sym_ce",    32'(sym_ce),    0);
        chk("midrst_ce_phase",  32'(ce_phase),  0);
        chk("midrst_lock_lost", 32'(lock_lost), 0);
        chk("midrst_drop_cnt",  32'(drop_cnt),  0);
        rst_n = 1'b1;
        wait_sys(1'b1, 40, n);
        chk("midrst_relock_lat", 32'(n), 32'(LAT));

        // Drop during hold-off at count 10 (lock_s falls at edge 17).
        locked = 1'b0;
        rst_n  = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        locked = 1'b1;
        for (int i = 0; i < 14; i++) step();
        locked = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("hold_drop_sys_rst_n", 32'(sys_rst_n), 0);
        chk("hold_drop_lock_lost", 32'(lock_lost), 0);
        chk("hold_drop_drop_cnt",  32'(drop_cnt),  0);

        // Glitch of 3 cycles, then a real lock.
        locked = 1'b1;
        for (int i = 0; i < 3; i++) step();
        locked = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("glitch_sys_rst_n", 32'(sys_rst_n), 0);
        end
        locked = 1'b1;
        wait_sys(1'b1, 40, n);
        chk("glitch_relock_lat", 32'(n), 32'(LAT));

        // Drop saturation and clr_flags priority.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_sys(1'b1, 40, n);
        chk("sat_start_lat", 32'(n), 32'(LAT));
        for (int i = 1; i <= 299; i++) begin
            locked = 1'b0;
            wait_sys(1'b0, 10, n);
            chk("sat_drop_seen", 32'(n > 0), 1);
            chk("sat_drop_cnt", 32'(drop_cnt), 32'(exp_drop(i)));
            locked = 1'b1;
            wait_sys(1'b1, 40, n);
        end
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_alone_lock_lost", 32'(lock_lost), 0);
        chk("clr_alone_drop_cnt",  32'(drop_cnt),  32'(exp_drop(299)));
        locked = 1'b0;
        step();
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_vs_drop_sys_rst_n", 32'(sys_rst_n), 0);
        chk("clr_vs_drop_lock_lost", 32'(lock_lost), 1);
        chk("clr_vs_drop_drop_cnt",  32'(drop_cnt),  32'(exp_drop(300)));
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        chk("clr_after_lock_lost", 32'(lock_lost), 0);
        chk("clr_after_drop_cnt",  32'(drop_cnt),  32'(exp_drop(300)));

        // Random lock activity against the model.
        for (int k = 0; k < 400; k++) begin
            locked = 1'($urandom_range(0, 1));
            len    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12))
                                                 : int'($urandom_range(20, 60));
            for (int j = 0; j < len; j++) begin
                clr_flags = ($urandom_range(0, 7) == 0);
                rst_n     = ($urandom_range(0, 299) != 0);
                step();
            end
        end
        rst_n     = 1'b1;
        clr_flags = 1'b0;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
